// File: rtl/host_frame_assembler_if.sv
// Byte-in / frame-out handshake bundle between the host UART receiver, the
// frame assembler and the sandbox process that consumes assembled frames.
interface host_frame_assembler_if;
  logic        rxValid;
  logic [7:0]  rxByte;
  logic        clearDR;
  logic        dataReceived;
  logic [7:0]  control;
  logic [31:0] inputData;
  logic        frameError;
  logic [7:0]  errorCount;
  logic        busy;

  modport master (
    output rxValid, rxByte, clearDR,
    input  dataReceived, control, inputData, frameError, errorCount, busy
  );

  modport slave (
    input  rxValid, rxByte, clearDR,
    output dataReceived, control, inputData, frameError, errorCount, busy
  );
endinterface

// File: rtl/host_frame_assembler.sv
// Assembles START/ctrl/d0..d3/chk byte frames into a control byte and a 32-bit
// word, holds them until released, and flags bad, stale or overrun frames.
module host_frame_assembler #(
  parameter logic [7:0] START_BYTE     = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         TO_WIDTH       = 17
) (
  input  logic                   masterClock,
  input  logic                   reset,
  host_frame_assembler_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, CTRL, DATA, CHECK, HOLD, WAIT_REL} state_t;

  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t              state;
  logic [7:0]          shCtrl;
  logic [3:0][7:0]     shData;
  logic [7:0]          runXor;
  logic [1:0]          idx;
  logic [TO_WIDTH-1:0] toCnt;
  logic                dataReceived;
  logic [7:0]          control;
  logic [31:0]         inputData;
  logic                frameError;
  logic [7:0]          errorCount;
  logic                assembling;
  logic                errNow;

  assign assembling = (state == CTRL) || (state == DATA) || (state == CHECK);

  // All error sources fold into one flag so coincident causes give one pulse.
  always_comb begin
    errNow = 1'b0;
    if ((state == HOLD || state == WAIT_REL) && bus.rxValid)
      errNow = 1'b1;
    if (state == CHECK && bus.rxValid && bus.rxByte != runXor)
      errNow = 1'b1;
    if (assembling && !bus.rxValid && toCnt == TO_LAST)
      errNow = 1'b1;
  end

  always_ff @(posedge masterClock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      shCtrl       <= '0;
      shData       <= '0;
      runXor       <= '0;
      idx          <= '0;
      toCnt        <= '0;
      dataReceived <= 1'b0;
      control      <= '0;
      inputData    <= '0;
      frameError   <= 1'b0;
      errorCount   <= '0;
    end else begin
      frameError <= errNow;
      if (errNow && errorCount != 8'hFF)
        errorCount <= errorCount + 8'd1;

      case (state)
        IDLE: begin
          toCnt <= '0;
          if (bus.rxValid && bus.rxByte == START_BYTE)
            state <= CTRL;
        end
        CTRL, DATA, CHECK: begin
          // A byte in the timeout cycle still counts as a valid byte.
          if (bus.rxValid) begin
            toCnt <= '0;
            if (state == CTRL) begin
              shCtrl <= bus.rxByte;
              runXor <= bus.rxByte;
              idx    <= '0;
              state  <= DATA;
            end else if (state == DATA) begin
              shData[idx] <= bus.rxByte;
              runXor      <= runXor ^ bus.rxByte;
              idx         <= idx + 2'd1;
              if (idx == 2'd3)
                state <= CHECK;
            end else if (bus.rxByte == runXor) begin
              control      <= shCtrl;
              inputData    <= shData;
              dataReceived <= 1'b1;
              state        <= HOLD;
            end else begin
              state <= IDLE;
            end
          end else if (toCnt == TO_LAST) begin
            toCnt <= '0;
            state <= IDLE;
          end else begin
            toCnt <= toCnt + 1'b1;
          end
        end
        HOLD: begin
          if (bus.clearDR) begin
            dataReceived <= 1'b0;
            state        <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!bus.clearDR)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dataReceived = dataReceived;
  assign bus.control      = control;
  assign bus.inputData    = inputData;
  assign bus.frameError   = frameError;
  assign bus.errorCount   = errorCount;
  assign bus.busy         = (state != IDLE);

endmodule

// File: tb/tb_host_frame_assembler.sv
// Directed-vector bench for host_frame_assembler with a short timeout.
module tb_host_frame_assembler;

  logic masterClock = 1'b0;
  logic reset       = 1'b0;
  int   nVec = 0;
  int   nMis = 0;

  host_frame_assembler_if bus ();

  host_frame_assembler #(
    .START_BYTE     (8'hA5),
    .TIMEOUT_CYCLES (16),
    .TO_WIDTH       (5)
  ) dut (
    .masterClock (masterClock),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 masterClock = ~masterClock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    if (obs !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge masterClock);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    bus.rxValid = 1'b1;
    bus.rxByte  = b;
    tick();
    bus.rxValid = 1'b0;
    bus.rxByte  = 8'h00;
  endtask

  task automatic sendHead(input logic [7:0] c, input logic [31:0] d);
    sendByte(8'hA5);
    sendByte(c);
    for (int i = 0; i < 4; i++) sendByte(d[i*8 +: 8]);
  endtask

  task automatic release_();
    bus.clearDR = 1'b1;
    tick();
    chk("clr_dr_low", bus.dataReceived, 0);
    bus.clearDR = 1'b0;
    tick();
    chk("clr_idle", bus.busy, 0);
  endtask

  initial begin
    bus.rxValid = 1'b0;
    bus.rxByte  = 8'h00;
    bus.clearDR = 1'b0;
    #2;
    chk("rst_dr",   bus.dataReceived, 0);
    chk("rst_ctrl", bus.control, 0);
    chk("rst_data", bus.inputData, 0);
    chk("rst_ferr", bus.frameError, 0);
    chk("rst_ecnt", bus.errorCount, 0);
    chk("rst_busy", bus.busy, 0);
    tick();
    reset = 1'b1;
    tick();

    // Valid frame, latency of one cycle after chk
    sendHead(8'h03, 32'h44332211);
    chk("v1_pre_dr", bus.dataReceived, 0);
    chk("v1_busy",   bus.busy, 1);
    sendByte(8'h47);
    chk("v1_dr",   bus.dataReceived, 1);
    chk("v1_ctrl", bus.control, 32'h03);
    chk("v1_data", bus.inputData, 32'h44332211);
    chk("v1_ferr", bus.frameError, 0);
    release_();

    // Bad checksum
    sendHead(8'h03, 32'h44332211);
    sendByte(8'h48);
    chk("bad_ferr", bus.frameError, 1);
    chk("bad_ecnt", bus.errorCount, 1);
    chk("bad_dr",   bus.dataReceived, 0);
    chk("bad_busy", bus.busy, 0);
    tick();
    chk("bad_pulse", bus.frameError, 0);
    chk("bad_ctrl",  bus.control, 32'h03);
    chk("bad_data",  bus.inputData, 32'h44332211);

    // START byte inside data, then overrun in HOLD and WAIT_REL
    sendHead(8'h01, 32'h000000A5);
    sendByte(8'hA4);
    chk("a5_dr",   bus.dataReceived, 1);
    chk("a5_data", bus.inputData, 32'h000000A5);
    sendByte(8'h55);
    chk("ovr_ferr", bus.frameError, 1);
    chk("ovr_ecnt", bus.errorCount, 2);
    chk("ovr_dr",   bus.dataReceived, 1);
    chk("ovr_data", bus.inputData, 32'h000000A5);
    bus.clearDR = 1'b1;
    tick();
    chk("wr_dr",   bus.dataReceived, 0);
    sendByte(8'h66);
    chk("wr_ferr", bus.frameError, 1);
    chk("wr_ecnt", bus.errorCount, 3);
    chk("wr_busy", bus.busy, 1);
    bus.clearDR = 1'b0;
    tick();
    chk("wr_idle", bus.busy, 0);

    // Timeout after 16 idle cycles
    sendByte(8'hA5);
    sendByte(8'h03);
    sendByte(8'h11);
    for (int i = 0; i < 15; i++) tick();
    chk("to_early_ferr", bus.frameError, 0);
    chk("to_early_busy", bus.busy, 1);
    tick();
    chk("to_ferr", bus.frameError, 1);
    chk("to_ecnt", bus.errorCount, 4);
    chk("to_idle", bus.busy, 0);
    sendHead(8'hC3, 32'hDDCCBBAA);
    sendByte(8'hC3);
    chk("to_v_dr",   bus.dataReceived, 1);
    chk("to_v_ctrl", bus.control, 32'hC3);
    chk("to_v_data", bus.inputData, 32'hDDCCBBAA);
    release_();

    // Garbage in IDLE, with clearDR high to show it is ignored
    bus.clearDR = 1'b1;
    sendByte(8'h00);
    sendByte(8'hFF);
    sendByte(8'h12);
    bus.clearDR = 1'b0;
    chk("gb_ferr", bus.frameError, 0);
    chk("gb_ecnt", bus.errorCount, 4);
    chk("gb_busy", bus.busy, 0);

    // Asynchronous reset mid-frame
    sendByte(8'hA5);
    sendByte(8'h03);
    sendByte(8'h11);
    #2;
    reset = 1'b0;
    #1;
    chk("mr_dr",   bus.dataReceived, 0);
    chk("mr_ctrl", bus.control, 0);
    chk("mr_data", bus.inputData, 0);
    chk("mr_ecnt", bus.errorCount, 0);
    chk("mr_busy", bus.busy, 0);
    tick();
    reset = 1'b1;
    tick();
    sendHead(8'h7E, 32'h04030201);
    sendByte(8'h7A);
    chk("mr_v_dr",   bus.dataReceived, 1);
    chk("mr_v_ctrl", bus.control, 32'h7E);
    chk("mr_v_data", bus.inputData, 32'h04030201);
    chk("mr_v_ecnt", bus.errorCount, 0);
    release_();

    // Saturation of the error counter
    for (int i = 0; i < 260; i++) begin
      sendHead(8'h03, 32'h44332211);
      sendByte(8'h48);
      if (i == 253) chk("sat_fe", bus.errorCount, 32'hFE);
    end
    chk("sat_ff",   bus.errorCount, 32'hFF);
    chk("sat_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
